// File: rtl/mnist_infer_seq_pkg.sv
// Shared types and defaults for the MNIST image sequencer.
// FSM state encoding plus image geometry defaults.
package mnist_infer_seq_pkg;

  localparam int IMG_SIZE_DEF = 784;
  localparam int PIX_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT,
    RESULT,
    DONE
  } state_t;

endpackage

// File: rtl/mnist_infer_seq_if.sv
// Pixel stream handshake toward the inference accelerator.
// Master drives data/valid/last, slave returns ready.
interface mnist_infer_seq_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_last;
  logic             pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/mnist_infer_seq_pix_streamer.sv
// ROM prefetch with a one-entry holding register.
// Streams IMG_SIZE pixels from base, one per cycle when unstalled.
module pix_streamer #(
  parameter int IMG_SIZE = 784,
  parameter int PIX_W    = 8,
  parameter int AW       = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [AW-1:0]    base,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  mnist_infer_seq_if.master pix
);

  localparam int KW = $clog2(IMG_SIZE + 1);

  logic [KW-1:0]    rd_cnt;
  logic             d_vld, d_last;
  logic             h_vld, h_last;
  logic [PIX_W-1:0] h_data;
  logic             issue, stall, rd_end;

  assign pix.pix_valid = h_vld | d_vld;
  assign pix.pix_data  = h_vld ? h_data
                       : (d_vld ? rom_data : '0);
  assign pix.pix_last  = h_vld ? h_last : (d_vld & d_last);

  assign stall  = pix.pix_valid & ~pix.pix_ready;
  assign rd_end = (rd_cnt == KW'(IMG_SIZE - 1));
  // A read may only be issued when its data has a free slot next cycle.
  assign issue  = (rd_cnt < KW'(IMG_SIZE)) &&
                  (!pix.pix_valid || pix.pix_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt   <= KW'(IMG_SIZE);
      rom_addr <= '0;
      d_vld    <= 1'b0;
      d_last   <= 1'b0;
      h_vld    <= 1'b0;
      h_last   <= 1'b0;
      h_data   <= '0;
    end else if (go) begin
      rd_cnt   <= '0;
      rom_addr <= base;
      d_vld    <= 1'b0;
      d_last   <= 1'b0;
      h_vld    <= 1'b0;
    end else begin
      d_vld  <= issue;
      d_last <= issue && rd_end;
      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (!rd_end) rom_addr <= rom_addr + 1'b1;
      end
      if (d_vld && stall) begin
        h_vld  <= 1'b1;
        h_data <= rom_data;
        h_last <= d_last;
      end else if (h_vld && pix.pix_ready) begin
        h_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mnist_infer_seq.sv
// Test-image sequencer: streams stored images to an accelerator,
// collects predictions and scores them against expected labels.
module mnist_infer_seq
  import mnist_infer_seq_pkg::*;
#(
  parameter int N_IMG    = 8,
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int TIMEOUT  = 65535,
  localparam int IW = (N_IMG > 1) ? $clog2(N_IMG) : 1,
  localparam int AW = $clog2(N_IMG * IMG_SIZE),
  localparam int CW = $clog2(N_IMG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [IW-1:0]    img_sel,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  input  logic [3:0]       label_in,
  mnist_infer_seq_if.master pix,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [3:0]       acc_pred,
  output logic [3:0]       digit,
  output logic             match,
  output logic [CW-1:0]    pass_cnt,
  output logic [IW-1:0]    cur_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] IMG_A = AW'(IMG_SIZE);

  state_t        state, state_nxt;
  logic          start_q, mode_q;
  logic          rise, accept, bad_sel;
  logic          go, tmo, hit;
  logic [IW-1:0] idx_nxt;
  logic [TW-1:0] wdog;
  logic [AW-1:0] base;

  assign rise    = start & ~start_q;
  assign bad_sel = ~mode & (int'(img_sel) >= N_IMG);
  assign tmo     = (wdog == TW'(TIMEOUT - 1));
  assign hit     = (acc_pred == label_in);
  assign base    = AW'(idx_nxt) * IMG_A;
  assign go      = (state_nxt == LOAD) && (state != LOAD);

  assign busy      = (state == LOAD) || (state == FIRE) ||
                     (state == WAIT) || (state == RESULT);
  assign done      = (state == DONE);
  assign acc_start = (state == FIRE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = cur_idx;
    accept    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (rise) begin
          accept    = 1'b1;
          idx_nxt   = mode ? '0 : img_sel;
          state_nxt = bad_sel ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (pix.pix_valid && pix.pix_ready && pix.pix_last)
          state_nxt = FIRE;
      end
      FIRE: state_nxt = WAIT;
      WAIT: begin
        if (acc_done) state_nxt = RESULT;
        else if (tmo) state_nxt = DONE;
      end
      RESULT: begin
        if (mode_q && int'(cur_idx) < N_IMG - 1) begin
          state_nxt = LOAD;
          idx_nxt   = cur_idx + 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b1;
      mode_q   <= 1'b0;
      cur_idx  <= '0;
      wdog     <= '0;
      digit    <= '0;
      match    <= 1'b0;
      pass_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      cur_idx <= idx_nxt;
      wdog    <= (state == WAIT) ? wdog + 1'b1 : '0;
      if (accept) begin
        mode_q   <= mode;
        pass_cnt <= '0;
        err      <= bad_sel;
      end
      if (state == WAIT && !acc_done && tmo) err <= 1'b1;
      if (state == RESULT) begin
        digit <= acc_pred;
        match <= hit;
        if (hit && int'(pass_cnt) < N_IMG)
          pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

  pix_streamer #(
    .IMG_SIZE (IMG_SIZE),
    .PIX_W    (PIX_W),
    .AW       (AW)
  ) u_strm (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .base     (base),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix      (pix)
  );

endmodule

// File: tb/tb_mnist_infer_seq.sv
// Directed bench for mnist_infer_seq with ROM and accelerator models.
// A second small instance covers the out-of-range image select.
module tb_mnist_infer_seq;
  import mnist_infer_seq_pkg::*;

  localparam int IMG = IMG_SIZE_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  img_sel = '0;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [3:0]  label_in;
  logic [3:0]  acc_pred = '0;
  logic        acc_start, acc_done;
  logic        acc_done_m = 1'b0;
  logic        spur = 1'b0;
  logic [3:0]  digit;
  logic        match, busy, done, err;
  logic [3:0]  pass_cnt;
  logic [2:0]  cur_idx;

  logic        start_b = 1'b0;
  logic [2:0]  sel_b = '0;
  logic [4:0]  rom_addr_b;
  logic [3:0]  digit_b;
  logic        match_b, acc_start_b, busy_b, done_b, err_b;
  logic [2:0]  pass_b, idx_b;

  logic [3:0]  lbl [8] = '{4'd3, 4'd1, 4'd4, 4'd1,
                           4'd5, 4'd9, 4'd2, 4'd6};
  bit          wrong [8];
  bit          rand_en = 1'b0;
  bit          acc_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_pix = '0;
  int          total = 0, bad = 0;
  int          nbeats = 0, nfire = 0, nvb = 0;
  int          beat = 0, mon_img = 0, mon_img0 = 0;
  int          cnt = 0;

  mnist_infer_seq_if #(.PIX_W(8)) pi ();
  mnist_infer_seq_if #(.PIX_W(8)) pb ();

  assign pb.pix_ready = 1'b1;
  assign label_in = lbl[cur_idx];
  assign acc_done = acc_done_m | spur;

  always #5 clk = ~clk;

  mnist_infer_seq #(
    .N_IMG(8), .IMG_SIZE(IMG), .PIX_W(8), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .img_sel(img_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .label_in(label_in), .pix(pi), .acc_start(acc_start),
    .acc_done(acc_done), .acc_pred(acc_pred), .digit(digit),
    .match(match), .pass_cnt(pass_cnt), .cur_idx(cur_idx),
    .busy(busy), .done(done), .err(err)
  );

  mnist_infer_seq #(
    .N_IMG(5), .IMG_SIZE(4), .PIX_W(8), .TIMEOUT(100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(1'b0),
    .img_sel(sel_b), .rom_addr(rom_addr_b), .rom_data(8'h00),
    .label_in(4'h0), .pix(pb), .acc_start(acc_start_b),
    .acc_done(1'b0), .acc_pred(4'h0), .digit(digit_b),
    .match(match_b), .pass_cnt(pass_b), .cur_idx(idx_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  function automatic logic [7:0] rom_fn(input int a);
    return 8'(a * 7 + a / 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int c;
    c = 0;
    while (!done && c < lim) begin
      step();
      c++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  always @(negedge clk) begin
    acc_done_m = 1'b0;
    if (acc_start && acc_en) begin
      cnt = 50;
      acc_pred = wrong[cur_idx] ? 4'((lbl[cur_idx] + 1) % 10)
                                : lbl[cur_idx];
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) acc_done_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    pi.pix_ready = rand_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
    if (!busy) begin
      beat = 0;
      mon_img = mon_img0;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(pi.pix_valid), 1);
      chk("stall_hold", {pi.pix_last, pi.pix_data}, prev_pix);
    end
    if (pi.pix_valid && pi.pix_ready) begin
      chk("pix_data", pi.pix_data, rom_fn(mon_img * IMG + beat));
      chk("pix_last", 32'(pi.pix_last), 32'(beat == IMG - 1));
      beat++;
      nbeats++;
      if (beat == IMG) begin
        beat = 0;
        mon_img++;
      end
    end
    prev_stall = rst_n && pi.pix_valid && !pi.pix_ready;
    prev_pix = {pi.pix_last, pi.pix_data};
    if (acc_start) nfire++;
    if (pb.pix_valid) nvb++;
  end

  initial begin
    int n, b0, f0, v0;
    repeat (3) step();
    chk("rst_outs", {digit, match, pass_cnt, cur_idx,
                     busy, done, err, acc_start}, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pix", {pi.pix_valid, pi.pix_last, pi.pix_data}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // single image 2, ready always high
    mode = 1'b0; img_sel = 3'd2; mon_img0 = 2;
    b0 = nbeats; f0 = nfire;
    pulse_start();
    chk("addr0", rom_addr, 1568);
    n = 0;
    while (!acc_start && n < 5000) begin
      n++;
      step();
    end
    chk("load_cycles", n, 785);
    wait_done(2000);
    chk("t1_beats", nbeats - b0, 784);
    chk("t1_fires", nfire - f0, 1);
    chk("t1_digit", digit, 4);
    chk("t1_match", match, 1);
    chk("t1_pass", pass_cnt, 1);
    chk("t1_flags", {busy, err}, 0);

    // single image 5 with random stalls
    img_sel = 3'd5; mon_img0 = 5; rand_en = 1'b1;
    b0 = nbeats;
    pulse_start();
    wait_done(4000);
    rand_en = 1'b0;
    chk("t2_beats", nbeats - b0, 784);
    chk("t2_digit", digit, 9);
    chk("t2_match", match, 1);
    chk("t2_pass", pass_cnt, 1);

    // sweep, wrong on 3 and 5, start toggled while busy
    wrong[3] = 1'b1; wrong[5] = 1'b1;
    mode = 1'b1; mon_img0 = 0;
    b0 = nbeats; f0 = nfire;
    pulse_start();
    repeat (200) step();
    chk("t3_busy", busy, 1);
    mode = 1'b0; img_sel = 3'd1;
    start = 1'b1; step(); start = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(12000);
    chk("t3_fires", nfire - f0, 8);
    chk("t3_beats", nbeats - b0, 8 * IMG);
    chk("t3_pass", pass_cnt, 6);
    chk("t3_idx", cur_idx, 7);
    chk("t3_digit", digit, 6);
    chk("t3_match", match, 1);
    chk("t3_err", err, 0);
    wrong[3] = 1'b0; wrong[5] = 1'b0;

    // watchdog: accelerator silent
    acc_en = 1'b0; img_sel = 3'd0; mon_img0 = 0;
    pulse_start();
    n = 0;
    while (!acc_start && n < 5000) begin
      n++;
      step();
    end
    chk("t4_fire", acc_start, 1);
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    chk("t4_wait_cyc", n, 101);
    chk("t4_err", err, 1);
    spur = 1'b1; step(); spur = 1'b0; step();
    chk("t4_hold", {digit, match, pass_cnt, done, err, busy},
        {4'd6, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    acc_en = 1'b1;

    // reset mid-stream with start held high
    img_sel = 3'd1; mon_img0 = 1;
    b0 = nbeats;
    pulse_start();
    n = 0;
    while (nbeats - b0 < 300 && n < 2000) begin
      step();
      n++;
    end
    chk("t5_beat300", nbeats - b0, 300);
    rst_n = 1'b0; start = 1'b1;
    step();
    chk("t5_outs", {digit, match, pass_cnt, cur_idx,
                    busy, done, err, acc_start}, 0);
    chk("t5_addr", rom_addr, 0);
    chk("t5_pix", {pi.pix_valid, pi.pix_last, pi.pix_data}, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t5_no_run", {busy, done}, 0);
    start = 1'b0;
    step();
    b0 = nbeats;
    pulse_start();
    wait_done(2000);
    chk("t5_beats", nbeats - b0, 784);
    chk("t5_digit", digit, 1);
    chk("t5_pass", pass_cnt, 1);

    // out-of-range select on the 5-image instance
    sel_b = 3'd6;
    v0 = nvb;
    step(); start_b = 1'b1; step(); start_b = 1'b0;
    n = 0;
    while (!done_b && n < 50) begin
      step();
      n++;
    end
    chk("t6_done", done_b, 1);
    chk("t6_err", err_b, 1);
    chk("t6_novalid", nvb - v0, 0);
    chk("t6_busy", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
